// File: rtl/inst_decode_pkg.sv
// Shared definitions for the pipelined instruction-decode stage.
// Holds the opcode/funct encodings, the packed control bundle carried in
// the ID/EX register, the all-zero NOP bundle and the pure decode function.
package inst_decode_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_INUART  = 6'h3C;
    localparam logic [5:0] OP_OUTUART = 6'h3D;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_srcs;
        logic       alu_srcs2;
        logic [3:0] alu_op;
        logic [1:0] reg_dist;
        logic [1:0] branch;
        logic       mem_write;
        logic       mem_read;
        logic       uart_to_reg;
        logic       reg_to_uart;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Anything not listed (including unknown R-type functs) decodes to NOP.
    function automatic ctrl_t decode_ctrl(input logic [31:0] inst);
        ctrl_t c;
        c = CTRL_NOP;
        case (inst[31:26])
            OP_RTYPE: begin
                if (inst[5:0] == FUNCT_ADD) begin
                    c.reg_write = 1'b1;
                    c.reg_dist  = 2'b01;
                    c.alu_op    = 4'h2;
                end else if (inst[5:0] == FUNCT_SUB) begin
                    c.reg_write = 1'b1;
                    c.reg_dist  = 2'b01;
                    c.alu_op    = 4'h6;
                end
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 2'b01;
                c.alu_srcs   = 2'b01;
                c.alu_op     = 4'h2;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_srcs  = 2'b01;
                c.alu_op    = 4'h2;
            end
            OP_BEQ: begin
                c.branch = 2'b01;
                c.alu_op = 4'h6;
            end
            OP_INUART: begin
                c.uart_to_reg = 1'b1;
                c.reg_write   = 1'b1;
            end
            OP_OUTUART: begin
                c.reg_to_uart = 1'b1;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register file with two combinational read ports and one write port.
// Ports: clk/reset (synchronous, active-high, clears every register),
// we/waddr/wdata write port, raddr1/raddr2 -> rdata1/rdata2 read ports.
// r0 always reads zero and ignores writes; reads of the register being
// written in the same cycle return the incoming write data.
module reg_file #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage update; the r0 slot is never written so it stays at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-first bypass so the decode stage sees the value being written back.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/inst_decode_pipe.sv
// Pipelined instruction-decode stage with ID/EX register.
// Inputs: inst/pc/pc1 with in_valid, flush, out_ready from EX, and the
// shared write port (RegWrite_before, UART_write_enable, address, data).
// Outputs: in_ready, out_valid, registered control fields, op1/op2,
// rt/rd/sa/immediate/inst_index, pc_next/pc1_next and sticky wr_conflict.
module inst_decode_pipe
    import inst_decode_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               inst,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [INST_MEM_WIDTH-1:0] pc1,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic                      RegWrite_before,
    input  logic                      UART_write_enable,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic [REG_ADDR_WIDTH-1:0] address,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      RegWrite,
    output logic [1:0]                MemtoReg,
    output logic [1:0]                ALUSrcs,
    output logic                      ALUSrcs2,
    output logic [3:0]                ALUOp,
    output logic [1:0]                RegDist,
    output logic [1:0]                Branch,
    output logic                      MemWrite,
    output logic                      MemRead,
    output logic                      UARTtoReg,
    output logic                      RegtoUART,
    output logic [DATA_WIDTH-1:0]     op1,
    output logic [DATA_WIDTH-1:0]     op2,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                sa,
    output logic [15:0]               immediate,
    output logic [25:0]               inst_index,
    output logic [INST_MEM_WIDTH-1:0] pc_next,
    output logic [INST_MEM_WIDTH-1:0] pc1_next,
    output logic                      wr_conflict
);
    ctrl_t                 ctrl_q;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;
    logic                  adv;
    logic                  hazard;
    logic                  wr_en;

    // Both write ports share address and data, so UART priority only matters
    // for flagging the collision; the written value is the same either way.
    assign wr_en = UART_write_enable || RegWrite_before;

    reg_file #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wr_en),
        .waddr  (address),
        .wdata  (data),
        .raddr1 (REG_ADDR_WIDTH'(inst[25:21])),
        .raddr2 (REG_ADDR_WIDTH'(inst[20:16])),
        .rdata1 (rs_val),
        .rdata2 (rt_val)
    );

    // A load sitting in ID/EX cannot forward its result in time, so a
    // dependent instruction is refused until a bubble separates them.
    always_comb begin
        adv      = !out_valid || out_ready;
        hazard   = out_valid && ctrl_q.mem_read && (rt != 5'd0) &&
                   ((rt == inst[25:21]) || (rt == inst[20:16])) && in_valid;
        in_ready = adv && !hazard;
    end

    // ID/EX register. Every path that drops out_valid also zeroes the
    // control bundle so no side-effecting control escapes on an empty slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            op1         <= '0;
            op2         <= '0;
            rt          <= '0;
            rd          <= '0;
            sa          <= '0;
            immediate   <= '0;
            inst_index  <= '0;
            pc_next     <= '0;
            pc1_next    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
                ctrl_q    <= CTRL_NOP;
            end else if (adv) begin
                if (in_valid && !hazard) begin
                    out_valid  <= 1'b1;
                    ctrl_q     <= decode_ctrl(inst);
                    op1        <= rs_val;
                    op2        <= rt_val;
                    rt         <= inst[20:16];
                    rd         <= inst[15:11];
                    sa         <= inst[10:6];
                    immediate  <= inst[15:0];
                    inst_index <= inst[25:0];
                    pc_next    <= pc;
                    pc1_next   <= pc1;
                end else begin
                    out_valid <= 1'b0;
                    ctrl_q    <= CTRL_NOP;
                end
            end
            if (UART_write_enable && RegWrite_before) begin
                wr_conflict <= 1'b1;
            end
        end
    end

    assign RegWrite  = ctrl_q.reg_write;
    assign MemtoReg  = ctrl_q.mem_to_reg;
    assign ALUSrcs   = ctrl_q.alu_srcs;
    assign ALUSrcs2  = ctrl_q.alu_srcs2;
    assign ALUOp     = ctrl_q.alu_op;
    assign RegDist   = ctrl_q.reg_dist;
    assign Branch    = ctrl_q.branch;
    assign MemWrite  = ctrl_q.mem_write;
    assign MemRead   = ctrl_q.mem_read;
    assign UARTtoReg = ctrl_q.uart_to_reg;
    assign RegtoUART = ctrl_q.reg_to_uart;

endmodule
